// File: rtl/feeder_pkg.sv
// feeder_pkg: state encoding, opcode constants and instruction field positions
// shared by instr_feeder and its store.
package feeder_pkg;

    localparam int unsigned WORD_W = 16;

    // Instruction word layout: [15:13] opcode, [12:10] X, [9:7] Y
    localparam int unsigned OP_MSB = 15;
    localparam int unsigned OP_LSB = 13;
    localparam int unsigned X_MSB  = 12;
    localparam int unsigned X_LSB  = 10;
    localparam int unsigned Y_MSB  = 9;
    localparam int unsigned Y_LSB  = 7;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HALT  = 3'd3,
        PAUSE = 3'd4
    } state_t;

    function automatic logic [2:0] field_op(input logic [WORD_W-1:0] w);
        return w[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [2:0] field_x(input logic [WORD_W-1:0] w);
        return w[X_MSB:X_LSB];
    endfunction

    function automatic logic [2:0] field_y(input logic [WORD_W-1:0] w);
        return w[Y_MSB:Y_LSB];
    endfunction

endpackage

// File: rtl/feeder_mem.sv
// feeder_mem: DEPTH x 16 program store, synchronous write, asynchronous read.
// Reads at or beyond DEPTH return 0 so a saturated pc never sees stale data.
module feeder_mem
    import feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [AW:0]       i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Store write; contents deliberately carry no reset
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so the top address bit flags out-of-range
    assign o_rdata = i_raddr[AW] ? '0 : r_mem[i_raddr[AW-1:0]];

endmodule

// File: rtl/instr_feeder.sv
// instr_feeder: program sequencer feeding DIN/Run to the processor core.
// Fetches one word per instruction, supplies the mvi immediate on the
// following cycle, and halts on program length or opcode 3'b111.
// Optional feature macro SINGLE_STEP_EN: adds input Step and a PAUSE state
// entered after every Done, left on Step.
module instr_feeder
    import feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [WORD_W-1:0] prog_data,
    input  logic [AW:0]       prog_len,
    input  logic              Done,
`ifdef SINGLE_STEP_EN
    input  logic              Step,
`endif
    output logic [WORD_W-1:0] DIN,
    output logic              Run,
    output logic [AW:0]       pc,
    output logic              busy,
    output logic              halted
);

    localparam int unsigned PCW    = AW + 1;
    localparam logic [AW:0] PC_MAX = PCW'(DEPTH);

    state_t            r_state;
    logic [AW:0]       r_pc;
    logic [AW:0]       r_len_q;
    logic              r_is_mvi;
    logic              r_busy;
    logic              r_halted;

    logic [WORD_W-1:0] w_word;
    logic [2:0]        w_op;
    logic              w_stop;
    logic              w_store_we;
    logic [AW:0]       w_pc_inc;
    logic              w_run;
    logic [WORD_W-1:0] w_din;

    // Program store is writable only while no program is executing
    assign w_store_we = prog_we & ((r_state == IDLE) | (r_state == HALT));

    feeder_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (Clock),
        .i_we    (w_store_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (r_pc),
        .o_rdata (w_word)
    );

    assign w_op     = field_op(w_word);
    assign w_stop   = (r_pc >= r_len_q) | (w_op == OP_HALT);
    // pc stops at DEPTH instead of wrapping back into the program
    assign w_pc_inc = (r_pc == PC_MAX) ? r_pc : r_pc + PCW'(1);

    // Core-facing drive: word presented in FETCH (with Run) and in WAIT
    always_comb begin
        w_run = 1'b0;
        w_din = '0;
        case (r_state)
            FETCH: begin
                w_run = ~w_stop;
                w_din = w_word;
            end
            WAIT: begin
                w_din = w_word;
            end
            default: begin
                w_run = 1'b0;
                w_din = '0;
            end
        endcase
    end

    // Sequencer FSM with pc, length latch and status flags
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state  <= IDLE;
            r_pc     <= '0;
            r_len_q  <= '0;
            r_is_mvi <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (Start) begin
                        r_len_q  <= prog_len;
                        r_pc     <= '0;
                        r_state  <= FETCH;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                FETCH: begin
                    if (w_stop) begin
                        r_state  <= HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_pc     <= w_pc_inc;
                        r_is_mvi <= (w_op == OP_MVI);
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    // is_mvi is only ever set on the first WAIT cycle
                    if (r_is_mvi) begin
                        r_pc     <= w_pc_inc;
                        r_is_mvi <= 1'b0;
                    end
                    if (Done) begin
`ifdef SINGLE_STEP_EN
                        r_state <= PAUSE;
`else
                        r_state <= FETCH;
`endif
                    end
                end
`ifdef SINGLE_STEP_EN
                PAUSE: begin
                    if (Step) begin
                        r_state <= FETCH;
                    end
                end
`endif
                default: begin
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign DIN    = w_din;
    assign Run    = w_run;
    assign pc     = r_pc;
    assign busy   = r_busy;
    assign halted = r_halted;

endmodule

// File: tb/tb_instr_feeder.sv
`timescale 1ns/1ps
// tb_instr_feeder: randomized programs against an instruction-level model of
// the fetch sequence plus a small core model that answers Done.
module tb_instr_feeder;
    import feeder_pkg::*;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PCW   = AW + 1;

    logic           Clock     = 1'b0;
    logic           Resetn    = 1'b0;
    logic           Start     = 1'b0;
    logic           prog_we   = 1'b0;
    logic [AW-1:0]  prog_addr = '0;
    logic [15:0]    prog_data = '0;
    logic [PCW-1:0] prog_len  = '0;
    logic           Done      = 1'b0;
`ifdef SINGLE_STEP_EN
    logic           Step      = 1'b0;
`endif
    logic [15:0]    DIN;
    logic           Run;
    logic [PCW-1:0] pc;
    logic           busy;
    logic           halted;

    instr_feeder #(.DEPTH(DEPTH)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Start     (Start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .Done      (Done),
`ifdef SINGLE_STEP_EN
        .Step      (Step),
`endif
        .DIN       (DIN),
        .Run       (Run),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [PCW-1:0] a;
        logic [15:0]    w;
    } fetch_t;

    logic [15:0]    shadow [DEPTH];
    fetch_t         exp_q [$];
    logic [PCW-1:0] halt_pc = '0;
    logic           chk_en = 1'b0, fetch_pend = 1'b0, imm_pend = 1'b0;
    logic           halt_pend = 1'b0, run_done = 1'b0, pause_pend = 1'b0;
    logic [15:0]    imm_exp = '0;

    logic [15:0]    R [8];
    int             run_count = 0;
    logic           rsp_active = 1'b0, rsp_first = 1'b0;
    logic [15:0]    rsp_ir = '0, rsp_imm = '0;
    int             rsp_cnt = 0;
    int             step_wait = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Walk the program as the spec describes it: list every fetched word and the halt address
    task automatic build_model(input int len);
        int a = 0;
        exp_q.delete();
        while (a < len && shadow[a][15:13] != OP_HALT) begin
            exp_q.push_back({PCW'(a), shadow[a]});
            a += (shadow[a][15:13] == OP_MVI) ? 2 : 1;
            if (a > int'(DEPTH)) a = DEPTH;
        end
        halt_pc = PCW'(a);
    endtask

    task automatic load_word(input int a, input logic [15:0] w);
        @(posedge Clock); #1;
        prog_we = 1'b1; prog_addr = AW'(a); prog_data = w;
        @(posedge Clock); #1;
        prog_we = 1'b0;
        shadow[a] = w;
    endtask

    task automatic clear_flags();
        fetch_pend = 1'b0; imm_pend = 1'b0; halt_pend = 1'b0; pause_pend = 1'b0; run_done = 1'b0;
    endtask

    // Start a program (optionally with a same-cycle store write) and wait for HALT
    task automatic run_prog(input int len, input bit ws_en, input int ws_addr,
                            input logic [15:0] ws_data, input bit inject);
        if (ws_en) shadow[ws_addr] = ws_data;
        build_model(len);
        clear_flags();
        @(posedge Clock); #1;
        Start = 1'b1; prog_len = PCW'(len);
        if (ws_en) begin
            prog_we = 1'b1; prog_addr = AW'(ws_addr); prog_data = ws_data;
        end
        @(posedge Clock); #1;
        Start = 1'b0; prog_we = 1'b0; fetch_pend = 1'b1; chk_en = 1'b1;
        if (inject) begin
            // First WAIT cycle: this write and Start must both be ignored
            @(posedge Clock); #1;
            prog_we = 1'b1; prog_addr = AW'(1); prog_data = 16'hE000;
            Start = 1'b1; prog_len = PCW'(1);
            @(posedge Clock); #1;
            prog_we = 1'b0; Start = 1'b0;
        end
        for (int i = 0; i < 2000 && !run_done; i++) @(posedge Clock);
        check("run completes", 32'(run_done), 32'(1));
        chk_en = 1'b0;
        #1;
    endtask

    // Core model: takes the word with Run, the immediate on the next cycle, answers Done
    initial begin : core_model
        forever begin
            @(posedge Clock); #1;
`ifdef SINGLE_STEP_EN
            Step = 1'b0;
            if (step_wait > 0) begin
                step_wait--;
                if (step_wait == 0) Step = 1'b1;
            end
`endif
            if (!Resetn) begin
                rsp_active = 1'b0; Done = 1'b0; step_wait = 0;
                for (int i = 0; i < 8; i++) R[i] = '0;
            end else if (Run) begin
                run_count++;
                rsp_ir = DIN; rsp_active = 1'b1; rsp_first = 1'b1; Done = 1'b0;
                if (field_op(DIN) == OP_ADD || field_op(DIN) == OP_SUB)
                    rsp_cnt = $urandom_range(1, 3);
                else
                    rsp_cnt = $urandom_range(0, 2);
            end else if (rsp_active) begin
                if (rsp_first && field_op(rsp_ir) == OP_MVI) rsp_imm = DIN;
                rsp_first = 1'b0;
                if (rsp_cnt == 0) begin
                    Done = 1'b1; rsp_active = 1'b0;
                    step_wait = $urandom_range(2, 4);
                    case (field_op(rsp_ir))
                        OP_MV:   R[field_x(rsp_ir)] = R[field_y(rsp_ir)];
                        OP_MVI:  R[field_x(rsp_ir)] = rsp_imm;
                        OP_ADD:  R[field_x(rsp_ir)] = R[field_x(rsp_ir)] + R[field_y(rsp_ir)];
                        OP_SUB:  R[field_x(rsp_ir)] = R[field_x(rsp_ir)] - R[field_y(rsp_ir)];
                        default: ;
                    endcase
                end else begin
                    rsp_cnt--; Done = 1'b0;
                end
            end else begin
                Done = 1'b0;
            end
        end
    end

    // Compare process: every cycle of a run checked against the fetch list
    initial begin : compare
        fetch_t e;
        forever begin
            @(negedge Clock);
            if (chk_en) begin
                if (imm_pend) begin
                    check("imm DIN", 32'(DIN), 32'(imm_exp));
                    check("imm Run", 32'(Run), 32'(0));
                    imm_pend = 1'b0;
                end else if (halt_pend) begin
                    check("halt halted", 32'(halted), 32'(1));
                    check("halt busy", 32'(busy), 32'(0));
                    check("halt Run", 32'(Run), 32'(0));
                    check("halt DIN", 32'(DIN), 32'(0));
                    check("halt pc", 32'(pc), 32'(halt_pc));
                    halt_pend = 1'b0; run_done = 1'b1;
                end
`ifdef SINGLE_STEP_EN
                if (pause_pend) begin
                    check("pause Run", 32'(Run), 32'(0));
                    check("pause DIN", 32'(DIN), 32'(0));
                    check("pause busy", 32'(busy), 32'(1));
                    if (Step) begin
                        pause_pend = 1'b0; fetch_pend = 1'b1;
                    end
                end else
`endif
                if (fetch_pend) begin
                    fetch_pend = 1'b0;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("fetch Run", 32'(Run), 32'(1));
                        check("fetch pc", 32'(pc), 32'(e.a));
                        check("fetch DIN", 32'(DIN), 32'(e.w));
                        check("fetch busy", 32'(busy), 32'(1));
                        if (e.w[15:13] == OP_MVI) begin
                            imm_pend = 1'b1;
                            imm_exp  = (int'(e.a) + 1 < int'(DEPTH)) ? shadow[int'(e.a) + 1] : 16'h0000;
                        end
                    end else begin
                        check("stop Run", 32'(Run), 32'(0));
                        check("stop pc", 32'(pc), 32'(halt_pc));
                        check("stop busy", 32'(busy), 32'(1));
                        halt_pend = 1'b1;
                    end
                end else if (Run) begin
                    check("spurious Run", 32'(Run), 32'(0));
                end
                if (Done) begin
`ifdef SINGLE_STEP_EN
                    pause_pend = 1'b1;
`else
                    fetch_pend = 1'b1;
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          len, rc0;
        logic [2:0]  op;
        bit          found;

        #12;
        check("reset Run", 32'(Run), 32'(0));
        check("reset DIN", 32'(DIN), 32'(0));
        check("reset pc", 32'(pc), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset halted", 32'(halted), 32'(0));
        @(negedge Clock); Resetn = 1'b1;
        for (int a = 0; a < int'(DEPTH); a++) load_word(a, 16'h0000);

        // mvi R0,#5 ; mv R1,R0 ; halt
        load_word(0, 16'h2000); load_word(1, 16'h0005);
        load_word(2, 16'h0400); load_word(3, 16'hE000);
        run_prog(4, 0, 0, '0, 0);
        check("t1 model halt pc", 32'(halt_pc), 32'(3));
        check("t1 pc", 32'(pc), 32'(3));
        check("t1 R0", 32'(R[0]), 32'(5));
        check("t1 R1", 32'(R[1]), 32'(5));

        // mvi R0,#3 ; mvi R1,#4 ; add R0,R1 ; halt
        load_word(0, 16'h2000); load_word(1, 16'h0003); load_word(2, 16'h2400);
        load_word(3, 16'h0004); load_word(4, 16'h4080); load_word(5, 16'hE000);
        run_prog(6, 0, 0, '0, 0);
        check("t2 pc", 32'(pc), 32'(5));
        check("t2 R0", 32'(R[0]), 32'(7));

        // Zero-length program halts without a Run pulse
        rc0 = run_count;
        run_prog(0, 0, 0, '0, 0);
        check("t3 run pulses", 32'(run_count - rc0), 32'(0));
        check("t3 pc", 32'(pc), 32'(0));

        // Two mv words, halt on length alone
        load_word(0, 16'h0400); load_word(1, 16'h0400);
        rc0 = run_count;
        run_prog(2, 0, 0, '0, 0);
        check("t4 run pulses", 32'(run_count - rc0), 32'(2));
        check("t4 pc", 32'(pc), 32'(2));

        // mvi at len-1 takes its immediate from beyond the program
        load_word(1, 16'h2000); load_word(2, 16'h1234);
        run_prog(2, 0, 0, '0, 0);
        check("t5 model halt pc", 32'(halt_pc), 32'(3));
        check("t5 R0", 32'(R[0]), 32'(16'h1234));

        // mvi in the last store word: immediate reads 0, pc saturates at DEPTH
        for (int a = 0; a < int'(DEPTH) - 1; a++) load_word(a, 16'h0400);
        load_word(DEPTH - 1, 16'h2000);
        run_prog(DEPTH, 0, 0, '0, 0);
        check("t6 model halt pc", 32'(halt_pc), 32'(DEPTH));
        check("t6 pc", 32'(pc), 32'(DEPTH));
        check("t6 R0", 32'(R[0]), 32'(0));

        // Store write and Start during WAIT are ignored; rerun reads the store back
        load_word(0, 16'h0400); load_word(1, 16'h0400);
        load_word(2, 16'h0400); load_word(3, 16'hE000);
        run_prog(4, 0, 0, '0, 1);
        check("t7 pc", 32'(pc), 32'(3));
        run_prog(4, 0, 0, '0, 0);
        check("t7 readback pc", 32'(pc), 32'(3));

        // Reset asserted during the WAIT of an add
        load_word(0, 16'h2000); load_word(1, 16'h0003);
        load_word(2, 16'h4000); load_word(3, 16'hE000);
        build_model(4);
        clear_flags();
        @(posedge Clock); #1;
        Start = 1'b1; prog_len = PCW'(4);
        @(posedge Clock); #1;
        Start = 1'b0; fetch_pend = 1'b1; chk_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge Clock);
            if (Run && DIN == 16'h4000) found = 1'b1;
        end
        check("t8 add fetched", 32'(found), 32'(1));
        @(posedge Clock); #2;
        chk_en = 1'b0;
        Resetn = 1'b0;
        #1;
        check("t8 reset Run", 32'(Run), 32'(0));
        check("t8 reset DIN", 32'(DIN), 32'(0));
        check("t8 reset pc", 32'(pc), 32'(0));
        check("t8 reset busy", 32'(busy), 32'(0));
        check("t8 reset halted", 32'(halted), 32'(0));
        exp_q.delete();
        clear_flags();
        @(negedge Clock); Resetn = 1'b1;

        // Write together with Start in IDLE: new word at address 0 is fetched
        run_prog(1, 1, 0, 16'h0400, 0);
        check("t9 pc", 32'(pc), 32'(1));
        // Rest of the store survived the reset
        run_prog(4, 0, 0, '0, 0);

        // Randomized programs
        for (int it = 0; it < 12; it++) begin
            len = $urandom_range(0, DEPTH);
            for (int a = 0; a <= len && a < int'(DEPTH); a++) begin
                op = ($urandom_range(0, 15) == 0) ? OP_HALT : 3'($urandom_range(0, 6));
                load_word(a, {op, 13'($urandom)});
            end
            run_prog(len, 0, 0, '0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
